fpga_config_ctrl: RTL
=====================

# fpga_config_ctrl

Synthesizable configuration sequencer for the `fpga` fabric. It accepts the bitstream as a narrow valid/ready word stream and assembles full-width configuration frames. Each frame is written into the fabric with a one-hot `configs_en` strobe. After the last frame it releases `ff_en` and then `rdy` with programmable settle delays. It replaces the file-driven behavioural loader in the top-level wrappers and sits between the bitstream source (SPI/JTAG bridge or boot ROM) and the `fpga` instance.

## Interface
- `FRAME_W`, 384: width of `configs_in`. Must be an integer multiple of `WORD_W`.
- `NUM_FRAMES`, 267: number of configuration regions, which is the width of `configs_en`.
- `WORD_W`, 32: width of the input bitstream word.
- `SETTLE_CYCLES`, 10: idle cycles in two places, last write to `ff_en`, and `ff_en` to `rdy`. Must be ≥1.
- Derived: `WPF` = `FRAME_W/WORD_W`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin (re)configuration; sampled in IDLE and READY only.
- `abort`  in  1  cancel an in-progress load.
- `s_data`  in  `WORD_W`  bitstream word.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  controller accepts a word this cycle.
- `configs_in`  out  `FRAME_W`  assembled frame to fabric.
- `configs_en`  out  `NUM_FRAMES`  one-hot frame write strobe.
- `ff_en`  out  1  fabric flip-flop enable.
- `rdy`  out  1  fabric configured and running.
- `busy`  out  1  load in progress.
- `frame_idx`  out  `$clog2(NUM_FRAMES)`  index of the frame currently being assembled or written.

## Operation
- States are IDLE, LOAD, WRITE, SETTLE, ARM and READY.
- **IDLE:** all outputs are 0. `start` moves to LOAD with `frame_idx`=0 and `word_cnt`=0.
- **LOAD:** `s_ready`=1.
  - On each accepted word (`s_valid && s_ready`): `configs_in <= {configs_in[FRAME_W-WORD_W-1:0], s_data}`. The first word of a frame therefore ends in the MSBs.
  - `word_cnt` increments on each accepted word. On the `WPF`-th word, `word_cnt` is cleared and the state moves to WRITE.
  - With `s_valid` low, the state holds with no timeout.
- **WRITE:** exactly one cycle. `configs_en` = one-hot at bit `frame_idx`, `s_ready`=0, `configs_in` stable.
  - If `frame_idx`==`NUM_FRAMES-1`, go to SETTLE.
  - Otherwise `frame_idx`+1 and go to LOAD.
- **SETTLE:** `configs_en`=0. Count `SETTLE_CYCLES` cycles, then go to ARM with `ff_en`=1.
- **ARM:** `ff_en`=1. Count `SETTLE_CYCLES` cycles, then go to READY with `rdy`=1.
- **READY:** `ff_en`=1 and `rdy`=1 are held. `start` clears `ff_en` and `rdy` on the next edge and goes to LOAD with `frame_idx`=0.
- **`configs_en` rule:** it is nonzero only in WRITE, and never has more than one bit set.
- **`configs_in` rule:** it changes only on accepted words and holds its value otherwise, including after the load completes.
- **`busy`:** 1 in LOAD, WRITE, SETTLE and ARM.
- **`abort`:**
  - In LOAD, WRITE, SETTLE or ARM: go to IDLE on the next edge and clear `word_cnt`, `frame_idx`, counters, `ff_en`, `rdy` and `configs_en`. `configs_in` is retained.
  - `abort` has priority over word acceptance in the same cycle; that word is not accepted, because `s_ready` is forced to 0 combinationally when `abort`=1.
  - `abort` is ignored in IDLE and READY.
- **`start` outside IDLE/READY:** ignored. `start` and `abort` asserted together in IDLE or READY: `start` wins.
- **Async reset:** all state and outputs go to 0 immediately, at any point including mid-frame. A partial frame is discarded.

## Timing
- **Reset values:** `s_ready`=0, `configs_in`=0, `configs_en`=0, `ff_en`=0, `rdy`=0, `busy`=0, `frame_idx`=0.
- **`start` to LOAD:** `start` sampled at edge N gives `s_ready`=1 and `busy`=1 from N+1.
- **Frame period:** with `s_valid` continuously high, a frame takes `WPF`+1 cycles (`WPF` LOAD cycles plus 1 WRITE cycle).
- **Total time, `start` to `rdy`:** 1 + `NUM_FRAMES*(WPF+1)` + 2*`SETTLE_CYCLES` cycles with no stalls. Each stalled cycle adds one.
- **`ff_en`:** rises `SETTLE_CYCLES` cycles after the final WRITE cycle ends.
- **`rdy`:** rises `SETTLE_CYCLES` cycles after `ff_en`.
- **Output registration:** all outputs are registered except `s_ready`. `s_ready` = (state==LOAD) && !`abort`.

## Test plan
Bench parameters: `FRAME_W`=64, `WORD_W`=32, `NUM_FRAMES`=3, `SETTLE_CYCLES`=4.

1. **Full load, no stalls:** `start`, then 6 words 0x11,0x22,…,0x66. The bench must see:
   - WRITE pulses with `configs_en`=001, 010, 100 and `configs_in`=0x00000011_00000022, 0x00000033_00000044, 0x00000055_00000066;
   - `ff_en` rising 4 cycles after the last pulse;
   - `rdy` 4 cycles later, 18 cycles after the `start` edge.
2. **Random `s_valid` stalls:** the same frame contents as scenario 1 must be produced.
   - Each stall delays `rdy` by exactly one cycle.
   - `configs_en` is never multi-hot and `configs_in` never changes during WRITE.
3. **`abort` during frame 1, word 1, with `s_valid` high:**
   - the word is not accepted;
   - IDLE next cycle with `busy`=0 and `frame_idx`=0;
   - a subsequent `start` plus 6 words behaves as scenario 1.
4. **Async `rst` low mid-SETTLE:** all outputs are 0 immediately, before the next clock edge. After release, IDLE with `rdy`=0.
5. **Reconfigure from READY:** `start` drops `ff_en` and `rdy` next cycle. A new 6-word load must reproduce `configs_en` pulses 001, 010, 100 and return to `rdy`=1.
6. **Ignored `start` during LOAD:** `start` while loading has no effect.

Source files
------------

// File: rtl/fpga_config_ctrl.sv
// Configuration sequencer: assembles narrow bitstream words into full frames,
// strobes each frame into the fabric, then releases ff_en and rdy after settle delays.
module fpga_config_ctrl #(
    parameter int FRAME_W       = 384,
    parameter int NUM_FRAMES    = 267,
    parameter int WORD_W        = 32,
    parameter int SETTLE_CYCLES = 10,
    localparam int IDX_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy,
    output logic [IDX_W-1:0]      frame_idx
);

    localparam int WPF   = FRAME_W / WORD_W;
    localparam int WC_W  = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WRITE  = 3'd2,
        SETTLE = 3'd3,
        ARM    = 3'd4,
        READY  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]        frame_idx_q, frame_idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0]      configs_in_q, configs_in_d;
    logic [NUM_FRAMES-1:0]   configs_en_q, configs_en_d;
    logic                    ff_en_q, rdy_q, busy_q;
    logic                    accept;

    // abort masks the handshake so a word offered in the abort cycle is never taken
    assign s_ready = (state_q == LOAD) && !abort;
    assign accept  = s_ready && s_valid;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        frame_idx_d  = frame_idx_q;
        cnt_d        = cnt_q;
        configs_in_d = configs_in_q;

        if (accept) begin
            configs_in_d = (configs_in_q << WORD_W) | FRAME_W'(s_data);
        end

        case (state_q)
            IDLE, READY: begin
                if (start) begin
                    state_d     = LOAD;
                    word_cnt_d  = '0;
                    frame_idx_d = '0;
                    cnt_d       = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    if (word_cnt_q == WC_W'(WPF - 1)) begin
                        word_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                end
            end
            WRITE: begin
                if (frame_idx_q == IDX_W'(NUM_FRAMES - 1)) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    frame_idx_d = frame_idx_q + IDX_W'(1);
                    state_d     = LOAD;
                end
            end
            SETTLE, ARM: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == SETTLE) ? ARM : READY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel any in-progress load; the assembled frame data is kept
        if (abort && (state_q inside {LOAD, WRITE, SETTLE, ARM})) begin
            state_d     = IDLE;
            word_cnt_d  = '0;
            frame_idx_d = '0;
            cnt_d       = '0;
        end
    end

    // Strobe is decoded from the next state so it is registered and aligned with WRITE
    for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_en
        assign configs_en_d[gi] = (state_d == WRITE) && (frame_idx_d == IDX_W'(gi));
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            frame_idx_q  <= '0;
            cnt_q        <= '0;
            configs_in_q <= '0;
            configs_en_q <= '0;
            ff_en_q      <= 1'b0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            frame_idx_q  <= frame_idx_d;
            cnt_q        <= cnt_d;
            configs_in_q <= configs_in_d;
            configs_en_q <= configs_en_d;
            ff_en_q      <= (state_d == ARM) || (state_d == READY);
            rdy_q        <= (state_d == READY);
            busy_q       <= state_d inside {LOAD, WRITE, SETTLE, ARM};
        end
    end

    assign configs_in = configs_in_q;
    assign configs_en = configs_en_q;
    assign ff_en      = ff_en_q;
    assign rdy        = rdy_q;
    assign busy       = busy_q;
    assign frame_idx  = frame_idx_q;

endmodule
